// File: rtl/dual_stream_arbiter_pkg.sv
// rtl/dual_stream_arbiter_pkg.sv - shared widths, beat layout and channel encoding for the arbiter
package dual_stream_arbiter_pkg;

    localparam int ADDRESS_WIDTH = 16;
    localparam int ID_WIDTH      = 4;
    localparam int ARB_Q_WIDTH   = 1 + ID_WIDTH + ADDRESS_WIDTH;

    typedef enum logic {
        CH1 = 1'b0,
        CH2 = 1'b1
    } chan_e;

    typedef struct packed {
        logic                     src;
        logic [ID_WIDTH-1:0]      id;
        logic [ADDRESS_WIDTH-1:0] address;
    } arb_beat_t;

    function automatic chan_e other_chan(input chan_e c);
        return (c == CH1) ? CH2 : CH1;
    endfunction

endpackage

// File: rtl/arb_fifo2.sv
// rtl/arb_fifo2.sv - two-entry synchronous FIFO with head-of-queue output
module arb_fifo2
    import dual_stream_arbiter_pkg::*;
#(
    parameter int WIDTH = ARB_Q_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [1:0]       count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    // A full queue still takes a push when the head leaves on the same edge.
    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/dual_stream_arbiter.sv
// rtl/dual_stream_arbiter.sv - round-robin merge of two stall-controlled producers into one queued port
module dual_stream_arbiter
    import dual_stream_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] in_address_1,
    input  logic [ID_WIDTH-1:0]      in_id_1,
    input  logic                     in_valid_1,
    output logic                     out_stall_1,
    input  logic [ADDRESS_WIDTH-1:0] in_address_2,
    input  logic [ID_WIDTH-1:0]      in_id_2,
    input  logic                     in_valid_2,
    output logic                     out_stall_2,
    input  logic                     in_enable_1,
    input  logic                     in_enable_2,
    input  logic                     in_stall,
    output logic [ADDRESS_WIDTH-1:0] out_address,
    output logic [ID_WIDTH-1:0]      out_id,
    output logic                     out_src,
    output logic                     out_valid
);

    logic                   stall_1_q, stall_1_d;
    logic                   stall_2_q, stall_2_d;
    chan_e                  rr_ptr_q, rr_ptr_d;
    logic                   acc_1, acc_2;
    logic                   push, pop;
    logic [1:0]             count;
    logic [2:0]             next_count;
    logic                   space;
    logic                   grant_any;
    chan_e                  grant_ch;
    arb_beat_t              push_beat;
    arb_beat_t              head_beat;
    logic [ARB_Q_WIDTH-1:0] head_data;

    // Only one stall is ever low, so at most one accept fires per edge.
    assign acc_1 = in_valid_1 && !stall_1_q;
    assign acc_2 = in_valid_2 && !stall_2_q;
    assign push  = acc_1 || acc_2;
    assign pop   = (count != 2'd0) && !in_stall;

    always_comb begin
        push_beat.src     = 1'b0;
        push_beat.id      = in_id_1;
        push_beat.address = in_address_1;
        if (acc_2) begin
            push_beat.src     = 1'b1;
            push_beat.id      = in_id_2;
            push_beat.address = in_address_2;
        end
    end

    // Granting only when at most one entry remains guarantees the granted beat fits
    // even if the downstream stalls for the whole next cycle.
    assign next_count = {1'b0, count} + {2'b00, push} - {2'b00, pop};
    assign space      = (next_count <= 3'd1);

    always_comb begin
        grant_any = 1'b0;
        grant_ch  = CH1;
        if (space) begin
            case ({in_enable_2, in_enable_1})
                2'b11: begin
                    grant_any = 1'b1;
                    grant_ch  = rr_ptr_q;
                end
                2'b01: begin
                    grant_any = 1'b1;
                    grant_ch  = CH1;
                end
                2'b10: begin
                    grant_any = 1'b1;
                    grant_ch  = CH2;
                end
                default: begin
                    grant_any = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        stall_1_d = 1'b1;
        stall_2_d = 1'b1;
        rr_ptr_d  = rr_ptr_q;
        if (grant_any) begin
            stall_1_d = (grant_ch != CH1);
            stall_2_d = (grant_ch != CH2);
            rr_ptr_d  = other_chan(grant_ch);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_1_q <= 1'b1;
            stall_2_q <= 1'b1;
            rr_ptr_q  <= CH1;
        end else begin
            stall_1_q <= stall_1_d;
            stall_2_q <= stall_2_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    arb_fifo2 #(
        .WIDTH(ARB_Q_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_data_i(push_beat),
        .pop_i      (pop),
        .count_o    (count),
        .head_o     (head_data)
    );

    assign head_beat   = head_data;
    assign out_address = head_beat.address;
    assign out_id      = head_beat.id;
    assign out_src     = head_beat.src;
    assign out_valid   = (count != 2'd0);
    assign out_stall_1 = stall_1_q;
    assign out_stall_2 = stall_2_q;

endmodule

// File: tb/tb_dual_stream_arbiter.sv
// tb/tb_dual_stream_arbiter.sv - randomized and directed bench for dual_stream_arbiter against a queue model
module tb_dual_stream_arbiter;
    import dual_stream_arbiter_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [ADDRESS_WIDTH-1:0] in_address_1, in_address_2, out_address;
    logic [ID_WIDTH-1:0]      in_id_1, in_id_2, out_id;
    logic                     in_valid_1, in_valid_2;
    logic                     out_stall_1, out_stall_2;
    logic                     in_enable_1, in_enable_2, in_stall;
    logic                     out_src, out_valid;
    logic                     want_1, want_2;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic                     src;
        logic [ID_WIDTH-1:0]      id;
        logic [ADDRESS_WIDTH-1:0] address;
    } exp_beat_t;

    exp_beat_t                mq[$];
    int                       m_grant;
    int                       m_pref;
    logic [ADDRESS_WIDTH-1:0] p_addr [1:2];
    logic [ID_WIDTH-1:0]      p_id   [1:2];

    always #5 clk = ~clk;

    assign in_valid_1 = want_1;
    assign in_valid_2 = want_2;

    dual_stream_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .in_address_1(in_address_1),
        .in_id_1     (in_id_1),
        .in_valid_1  (in_valid_1),
        .out_stall_1 (out_stall_1),
        .in_address_2(in_address_2),
        .in_id_2     (in_id_2),
        .in_valid_2  (in_valid_2),
        .out_stall_2 (out_stall_2),
        .in_enable_1 (in_enable_1),
        .in_enable_2 (in_enable_2),
        .in_stall    (in_stall),
        .out_address (out_address),
        .out_id      (out_id),
        .out_src     (out_src),
        .out_valid   (out_valid)
    );

    function automatic void model_reset();
        mq.delete();
        m_grant   = 0;
        m_pref    = 1;
        p_addr[1] = '0;
        p_addr[2] = '0;
        p_id[1]   = '0;
        p_id[2]   = '0;
    endfunction

    // Model of one rising edge: retire, accept, then choose next cycle's grant.
    function automatic void model_edge();
        bit acc1, acc2, pop;
        int nc;
        acc1 = in_valid_1 && (m_grant == 1);
        acc2 = in_valid_2 && (m_grant == 2);
        pop  = (mq.size() != 0) && !in_stall;
        nc   = mq.size() + ((acc1 || acc2) ? 1 : 0) - (pop ? 1 : 0);
        if (pop) void'(mq.pop_front());
        for (int k = 1; k <= 2; k++) begin
            if ((k == 1 && acc1) || (k == 2 && acc2)) begin
                mq.push_back({(k == 2), p_id[k], p_addr[k]});
                p_id[k]   = p_id[k] + 1'b1;
                p_addr[k] = p_addr[k] + ADDRESS_WIDTH'(4);
            end
        end
        m_grant = 0;
        if (nc <= 1) begin
            if (in_enable_1 && in_enable_2) m_grant = m_pref;
            else if (in_enable_1)           m_grant = 1;
            else if (in_enable_2)           m_grant = 2;
            if (m_grant != 0) m_pref = 3 - m_grant;
        end
    endfunction

    function automatic logic [2:0] exp_ctrl();
        return {(m_grant != 1), (m_grant != 2), (mq.size() != 0)};
    endfunction

    task automatic drive_inputs();
        in_address_1 = p_addr[1];
        in_id_1      = p_id[1];
        in_address_2 = p_addr[2];
        in_id_2      = p_id[2];
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        @(negedge clk);
        drive_inputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        drive_inputs();
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        want_1      = 1'b1;
        want_2      = 1'b1;
        in_enable_1 = 1'b1;
        in_enable_2 = 1'b1;
        in_stall    = 1'b0;
        model_reset();
        drive_inputs();
        repeat (2) tick();
        n_checks++;
        if ({out_stall_1, out_stall_2, out_valid, out_src, out_id, out_address} !==
            {1'b1, 1'b1, 1'b0, 1'b0, {ID_WIDTH{1'b0}}, {ADDRESS_WIDTH{1'b0}}}) begin
            n_errors++;
            $display("FAIL reset_state got s1=%b s2=%b v=%b src=%b id=%0d addr=%0d want 1 1 0 0 0 0",
                     out_stall_1, out_stall_2, out_valid, out_src, out_id, out_address);
        end
        reset = 1'b0;
    endtask

    task automatic test_both_streaming();
        int j;
        exp_beat_t e;
        do_reset();
        in_enable_1 = 1'b1; in_enable_2 = 1'b1; in_stall = 1'b0; want_1 = 1'b1; want_2 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_checks++;
            if ({out_stall_1, out_stall_2, out_valid} !== exp_ctrl()) begin
                n_errors++;
                $display("FAIL both_ctrl cyc %0d got %b want %b", c, {out_stall_1, out_stall_2, out_valid}, exp_ctrl());
            end
            if (mq.size() != 0) begin
                n_checks++;
                if ({out_src, out_id, out_address} !== mq[0]) begin
                    n_errors++;
                    $display("FAIL both_head cyc %0d got %h want %h", c, {out_src, out_id, out_address}, mq[0]);
                end
            end
            if (c >= 2 && c <= 6) begin
                j = c - 2;
                e = {1'(j % 2), ID_WIDTH'(j / 2), ADDRESS_WIDTH'((j / 2) * 4)};
                n_checks++;
                if ({out_valid, out_src, out_id, out_address} !== {1'b1, e}) begin
                    n_errors++;
                    $display("FAIL both_seq cyc %0d got v=%b %h want v=1 %h", c, out_valid, {out_src, out_id, out_address}, e);
                end
            end
        end
    endtask

    task automatic test_single_channel();
        do_reset();
        in_enable_1 = 1'b0; in_enable_2 = 1'b1; in_stall = 1'b0; want_1 = 1'b1; want_2 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            n_checks++;
            if ({out_stall_1, out_stall_2, out_valid} !== exp_ctrl()) begin
                n_errors++;
                $display("FAIL single_ctrl cyc %0d got %b want %b", c, {out_stall_1, out_stall_2, out_valid}, exp_ctrl());
            end
            if (c >= 2) begin
                n_checks++;
                if ({out_stall_1, out_valid, out_src, out_address} !== {1'b1, 1'b1, 1'b1, ADDRESS_WIDTH'(4 * (c - 2))}) begin
                    n_errors++;
                    $display("FAIL single_seq cyc %0d got s1=%b v=%b src=%b addr=%0d want 1 1 1 %0d",
                             c, out_stall_1, out_valid, out_src, out_address, 4 * (c - 2));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_enable_1 = 1'b1; in_enable_2 = 1'b1; in_stall = 1'b0; want_1 = 1'b1; want_2 = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            if (c == 7)  in_stall = 1'b1;
            if (c == 12) in_stall = 1'b0;
            tick();
            n_checks++;
            if ({out_stall_1, out_stall_2, out_valid} !== exp_ctrl()) begin
                n_errors++;
                $display("FAIL bp_ctrl cyc %0d got %b want %b", c, {out_stall_1, out_stall_2, out_valid}, exp_ctrl());
            end
            if (mq.size() != 0) begin
                n_checks++;
                if ({out_src, out_id, out_address} !== mq[0]) begin
                    n_errors++;
                    $display("FAIL bp_head cyc %0d got %h want %h", c, {out_src, out_id, out_address}, mq[0]);
                end
            end
            if (c == 11) begin
                n_checks++;
                if ({out_stall_1, out_stall_2, out_valid} !== 3'b111) begin
                    n_errors++;
                    $display("FAIL bp_full got %b want 111", {out_stall_1, out_stall_2, out_valid});
                end
            end
        end
    endtask

    task automatic test_disable();
        do_reset();
        in_enable_1 = 1'b1; in_enable_2 = 1'b1; in_stall = 1'b0; want_1 = 1'b1; want_2 = 1'b1;
        repeat (4) tick();
        in_stall = 1'b1;
        repeat (3) tick();
        in_enable_1 = 1'b0; in_enable_2 = 1'b0; in_stall = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 7) in_enable_1 = 1'b1;
            tick();
            n_checks++;
            if ({out_stall_1, out_stall_2, out_valid} !== exp_ctrl()) begin
                n_errors++;
                $display("FAIL dis_ctrl cyc %0d got %b want %b", c, {out_stall_1, out_stall_2, out_valid}, exp_ctrl());
            end
            if (mq.size() != 0) begin
                n_checks++;
                if ({out_src, out_id, out_address} !== mq[0]) begin
                    n_errors++;
                    $display("FAIL dis_head cyc %0d got %h want %h", c, {out_src, out_id, out_address}, mq[0]);
                end
            end
            if (c == 5) begin
                n_checks++;
                if ({out_stall_1, out_stall_2, out_valid} !== 3'b110) begin
                    n_errors++;
                    $display("FAIL dis_drained got %b want 110", {out_stall_1, out_stall_2, out_valid});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_enable_1 = 1'b1; in_enable_2 = 1'b1; in_stall = 1'b0; want_1 = 1'b1; want_2 = 1'b1;
        repeat (5) tick();
        in_stall = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({out_stall_1, out_stall_2, out_valid, out_src, out_id, out_address} !==
            {1'b1, 1'b1, 1'b0, 1'b0, {ID_WIDTH{1'b0}}, {ADDRESS_WIDTH{1'b0}}}) begin
            n_errors++;
            $display("FAIL reset_mid got s1=%b s2=%b v=%b src=%b id=%0d addr=%0d want 1 1 0 0 0 0",
                     out_stall_1, out_stall_2, out_valid, out_src, out_id, out_address);
        end
        model_reset();
        tick();
        reset = 1'b0; in_stall = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_checks++;
            if ({out_stall_1, out_stall_2, out_valid} !== exp_ctrl()) begin
                n_errors++;
                $display("FAIL rmid_ctrl cyc %0d got %b want %b", c, {out_stall_1, out_stall_2, out_valid}, exp_ctrl());
            end
            if (c == 2) begin
                n_checks++;
                if ({out_valid, out_src, out_id, out_address} !== {1'b1, 1'b0, {ID_WIDTH{1'b0}}, {ADDRESS_WIDTH{1'b0}}}) begin
                    n_errors++;
                    $display("FAIL rmid_first got v=%b src=%b id=%0d addr=%0d want 1 0 0 0", out_valid, out_src, out_id, out_address);
                end
            end
        end
    endtask

    task automatic test_id_wrap();
        int n;
        do_reset();
        in_enable_1 = 1'b1; in_enable_2 = 1'b0; in_stall = 1'b0; want_1 = 1'b1; want_2 = 1'b1;
        for (int c = 1; c <= (1 << ID_WIDTH) + 4; c++) begin
            tick();
            if (c >= 2) begin
                n = c - 2;
                n_checks++;
                if ({out_valid, out_src, out_id, out_address} !==
                    {1'b1, 1'b0, ID_WIDTH'(n % (1 << ID_WIDTH)), ADDRESS_WIDTH'(4 * n)}) begin
                    n_errors++;
                    $display("FAIL wrap beat %0d got v=%b src=%b id=%0d addr=%0d want 1 0 %0d %0d",
                             n, out_valid, out_src, out_id, out_address, n % (1 << ID_WIDTH), 4 * n);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 1; c <= 1500; c++) begin
            if ($urandom_range(0, 7) == 0) in_enable_1 = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) in_enable_2 = ($urandom_range(0, 3) != 0);
            in_stall = ($urandom_range(0, 3) == 0);
            want_1   = ($urandom_range(0, 4) != 0);
            want_2   = ($urandom_range(0, 4) != 0);
            tick();
            n_checks++;
            if ({out_stall_1, out_stall_2, out_valid} !== exp_ctrl()) begin
                n_errors++;
                $display("FAIL rand_ctrl cyc %0d got %b want %b", c, {out_stall_1, out_stall_2, out_valid}, exp_ctrl());
            end
            if (mq.size() != 0) begin
                n_checks++;
                if ({out_src, out_id, out_address} !== mq[0]) begin
                    n_errors++;
                    $display("FAIL rand_head cyc %0d got %h want %h", c, {out_src, out_id, out_address}, mq[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_both_streaming();
        test_single_channel();
        test_backpressure();
        test_disable();
        test_reset_mid();
        test_id_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dual_stream_arbiter.md
# dual_stream_arbiter

Round-robin arbiter that merges the two stall-controlled producer streams into one downstream address/ID port. It owns both producers' stall inputs and grants at most one producer per cycle. Accepted beats are buffered in a 2-entry output queue so the downstream stall never drops or duplicates a beat. It sits between the dual-channel producer and the single-port consumer.

## Interface
- Parameters: none. Widths come from `ADDRESS_WIDTH` and `ID_WIDTH` in `defines.vh`.
- Ports:
  - `clk` in, 1: the single clock; all state on its rising edge.
  - `reset` in, 1: asynchronous, active-high.
  - `in_address_1` in, `ADDRESS_WIDTH`: channel-1 producer address.
  - `in_id_1` in, `ID_WIDTH`: channel-1 producer ID.
  - `in_valid_1` in, 1: channel-1 producer valid.
  - `out_stall_1` out, 1: stall to the channel-1 producer; registered.
  - `in_address_2`, `in_id_2`, `in_valid_2`, `out_stall_2`: same as above, for channel 2.
  - `in_enable_1` in, 1: channel-1 arbitration enable.
  - `in_enable_2` in, 1: channel-2 arbitration enable.
  - `in_stall` in, 1: downstream stall.
  - `out_address` out, `ADDRESS_WIDTH`: merged-stream address.
  - `out_id` out, `ID_WIDTH`: merged-stream ID.
  - `out_src` out, 1: source channel; 0 = channel 1, 1 = channel 2.
  - `out_valid` out, 1: queue head valid.

## Operation
- **Accept rule.** A producer beat is accepted at a rising edge when `in_valid_k && !out_stall_k`. The beat (address, ID, source) is pushed into the queue on that edge.
- **Registered stalls.** `out_stall_1` and `out_stall_2` are registered, with no combinational path from any input. This is mandatory: producer valid is combinationally `!stall`.
- **One grant per cycle.** At most one of `out_stall_1` / `out_stall_2` is low in any cycle.
- **Grant decision**, made each edge for the following cycle:
  - `next_count = count + push - pop`, where `pop = out_valid && !in_stall`.
  - A grant is allowed only if `next_count <= 1`. A push next cycle then always fits without relying on a pop.
  - Eligible channels are those with `in_enable_k = 1`.
  - If both are eligible, grant the channel pointed to by `rr_ptr`, then flip `rr_ptr` to the other channel.
  - If exactly one is eligible, grant it; `rr_ptr` is set to the other channel.
  - If none is eligible, or there is no space, both stalls are 1.
- **Queue.** 2-entry FIFO of {src, id, address}.
  - `out_*` always show the head entry; `out_valid = (count != 0)`.
  - The head holds stable while `in_stall = 1`.
  - Simultaneous push and pop is legal at count 1 or 2; count is unchanged.
- **Enable change.** Takes effect at the next grant decision. A grant already issued for the current cycle completes.
- **Both channels disabled.** No grants; the queue drains normally.
- **Reset.** Asserted at any time (including mid-transfer), it immediately forces:
  - `out_stall_1 = out_stall_2 = 1`
  - `out_valid = 0`, queue empty (count 0)
  - `out_address = 0`, `out_id = 0`, `out_src = 0`
  - `rr_ptr = channel 1`
  - Any queued beats are discarded.

## Timing
- First grant: in the cycle after the first edge following reset release (cycle 1). `out_stall_1 = 0` in that cycle if channel 1 is enabled.
- Latency: a beat accepted at edge N appears on `out_*` in cycle N (immediately after that edge) if the queue was empty.
- Throughput: one beat per cycle with `in_stall = 0` continuously. The stream alternates 1, 2, 1, 2 when both channels are enabled.
- Downstream stall: with `in_stall` held high, at most 2 beats are queued. Stalls go high within one cycle of the queue reaching the limit, and no beat is lost.
- Stall release: after `in_stall` falls, grants resume by the following cycle.

## Structure
- `defines.vh` supplies `ADDRESS_WIDTH` and `ID_WIDTH`.
- Add `ARB_Q_WIDTH` = 1 + `ID_WIDTH` + `ADDRESS_WIDTH` to `defines.vh`.
- Sub-module `arb_fifo2`: 2-entry synchronous FIFO with async active-high reset, push/pop/count ports, and head data output.
- The top level holds the round-robin pointer, the grant-decision logic and the stall registers.

## Test plan
1. **Both channels streaming.** Both enabled, `in_stall = 0`, connected to the dual producer. Outputs from cycle 2 are (src, addr, id) = (0,0,0), (1,0,0), (0,4,1), (1,4,1), (0,8,2), one per cycle.
2. **Single channel.** Only `in_enable_2 = 1`. Every output has `src = 1`, addresses 0, 4, 8, ... on consecutive cycles. `out_stall_1` stays 1.
3. **Downstream backpressure.** Hold `in_stall = 1` for 5 cycles mid-stream. The queue holds 2 beats, both stalls are 1, and the head is stable. After release the sequence continues with no gap in IDs per source.
4. **Both channels disabled.** Disable both with 2 beats queued. Exactly 2 beats drain, then `out_valid = 0` and both stalls stay 1. Re-enable channel 1 and its next ID follows the last accepted one.
5. **Reset mid-operation.** Assert `reset` asynchronously with a non-empty queue. `out_valid` is 0 immediately, both stalls are 1, and after release the first output is (0,0,0).
6. **ID wrap.** Run channel 1 until its ID wraps at 2^`ID_WIDTH`. The output ID goes from max to 0 and the address continues to increase by 4.
